// File: rtl/ram_dma_steal_pkg.sv
// ram_dma_steal_pkg
//   Shared definitions for the cycle-stealing block copy/fill engine:
//   FSM state encoding and default address/length widths.
package ram_dma_steal_pkg;

    localparam int DEF_AW = 16;  // ram address width
    localparam int DEF_LW = 16;  // transfer length width (bytes)

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } dma_state_t;

endpackage

// File: rtl/ram_dma_steal.sv
// ram_dma_steal
//   Cycle-stealing block copy/fill engine placed between the cdp1802 core
//   and a shared single-port ram. The CPU cannot be stalled, so it always
//   owns the ram whenever it strobes rd or wr; the DMA sequencer only uses
//   cycles in which the CPU is idle.
//
// Ports
//   clock, resetq             : clock, synchronous active-low reset
//   cpu_rd/cpu_wr/cpu_a/cpu_d : CPU ram request
//   cpu_q                     : read data back to the CPU (ram_q passthrough)
//   ram_re/ram_we/ram_a/ram_d : muxed ram request
//   ram_q                     : ram read data, valid the cycle after ram_re
//   cfg_start/cfg_fill/cfg_src/cfg_dst/cfg_len/cfg_val : transfer setup
//   cfg_abort                 : abandon current transfer (no done pulse)
//   busy                      : transfer in progress
//   done                      : one-cycle pulse on normal completion
//   stolen                    : ram cycles used by DMA since last start
module ram_dma_steal
    import ram_dma_steal_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int LW = DEF_LW
) (
    input  logic          clock,
    input  logic          resetq,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    output logic          ram_re,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    input  logic [7:0]    ram_q,
    input  logic          cfg_start,
    input  logic          cfg_fill,
    input  logic [AW-1:0] cfg_src,
    input  logic [AW-1:0] cfg_dst,
    input  logic [LW-1:0] cfg_len,
    input  logic [7:0]    cfg_val,
    input  logic          cfg_abort,
    output logic          busy,
    output logic          done,
    output logic [15:0]   stolen
);

    dma_state_t    state, state_nxt;
    logic [AW-1:0] src_q, dst_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_m1;
    logic          fill_q;
    logic [7:0]    val_q;
    logic [7:0]    data_buf;
    logic [15:0]   stolen_q;

    logic cpu_idle;
    logic dma_re, dma_we;
    logic start_ok;

    assign cpu_idle = !cpu_rd && !cpu_wr;
    assign dma_re   = (state == ST_RD) && cpu_idle;
    assign dma_we   = (state == ST_WR) && cpu_idle;
    // Abort wins over start when both arrive in IDLE.
    assign start_ok = (state == ST_IDLE) && cfg_start && !cfg_abort;
    assign len_m1   = len_q - LW'(1);

    assign cpu_q  = ram_q;
    assign busy   = (state != ST_IDLE);
    // An abort landing on the FIN cycle suppresses the completion pulse.
    assign done   = (state == ST_FIN) && !cfg_abort;
    assign stolen = stolen_q;

    // ram request mux: CPU first, otherwise DMA in RD/WR, otherwise quiet.
    always_comb begin
        ram_re = 1'b0;
        ram_we = 1'b0;
        ram_a  = '0;
        ram_d  = '0;
        if (!cpu_idle) begin
            ram_re = cpu_rd;
            ram_we = cpu_wr;
            ram_a  = cpu_a;
            ram_d  = cpu_d;
        end else if (dma_re) begin
            ram_re = 1'b1;
            ram_a  = src_q;
        end else if (dma_we) begin
            ram_we = 1'b1;
            ram_a  = dst_q;
            ram_d  = fill_q ? val_q : data_buf;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    if (cfg_len == '0)
                        state_nxt = ST_FIN;
                    else if (cfg_fill)
                        state_nxt = ST_WR;
                    else
                        state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                if (cpu_idle)
                    state_nxt = ST_CAP;
            end
            // The read issued in RD returns now regardless of what the CPU
            // is doing, so CAP never waits.
            ST_CAP: state_nxt = ST_WR;
            ST_WR: begin
                if (cpu_idle) begin
                    if (len_m1 == '0)
                        state_nxt = ST_FIN;
                    else if (fill_q)
                        state_nxt = ST_WR;
                    else
                        state_nxt = ST_RD;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (cfg_abort && (state != ST_IDLE))
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!resetq) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            fill_q   <= 1'b0;
            val_q    <= '0;
            data_buf <= '0;
            stolen_q <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                src_q    <= cfg_src;
                dst_q    <= cfg_dst;
                len_q    <= cfg_len;
                fill_q   <= cfg_fill;
                val_q    <= cfg_val;
                stolen_q <= '0;
            end
            // start_ok only happens in IDLE, where no DMA cycle is stolen.
            if (dma_re || dma_we)
                stolen_q <= stolen_q + 16'd1;
            if (state == ST_CAP)
                data_buf <= ram_q;
            if (dma_we) begin
                src_q <= src_q + AW'(1);
                dst_q <= dst_q + AW'(1);
                if (len_q != '0)
                    len_q <= len_m1;
            end
        end
    end

endmodule
